// File: rtl/ef_aes_wb_slave_pkg.sv
// Shared definitions for the AES-128 Wishbone peripheral.
// Holds the register offsets, the STATUS bit positions, the round count,
// the Rcon table and the core sequencing states.
package ef_aes_wb_slave_pkg;

    localparam logic [7:0] KEY0_OFF   = 8'h00;
    localparam logic [7:0] KEY1_OFF   = 8'h04;
    localparam logic [7:0] KEY2_OFF   = 8'h08;
    localparam logic [7:0] KEY3_OFF   = 8'h0C;
    localparam logic [7:0] DIN0_OFF   = 8'h10;
    localparam logic [7:0] DIN1_OFF   = 8'h14;
    localparam logic [7:0] DIN2_OFF   = 8'h18;
    localparam logic [7:0] DIN3_OFF   = 8'h1C;
    localparam logic [7:0] DOUT0_OFF  = 8'h20;
    localparam logic [7:0] DOUT1_OFF  = 8'h24;
    localparam logic [7:0] DOUT2_OFF  = 8'h28;
    localparam logic [7:0] DOUT3_OFF  = 8'h2C;
    localparam logic [7:0] CTRL_OFF   = 8'h30;
    localparam logic [7:0] STATUS_OFF = 8'h34;
    localparam logic [7:0] IM_OFF     = 8'h38;
    localparam logic [7:0] RIS_OFF    = 8'h3C;
    localparam logic [7:0] MIS_OFF    = 8'h40;
    localparam logic [7:0] ICR_OFF    = 8'h44;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    localparam int NR = 10;

    localparam logic [0:9][7:0] RCON_TABLE = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        CORE_IDLE  = 2'd0,
        CORE_ROUND = 2'd1,
        CORE_LOAD  = 2'd2
    } core_state_t;

    // Round constant for key-expansion step idx (0 => round 1).
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < NR; i++) begin
            if (idx == 4'(i)) r = RCON_TABLE[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
// Ports: value - input byte; subst - substituted byte.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign subst = SBOX[value];

endmodule

// File: rtl/ef_aes_wb_slave.sv
// AES-128 encrypt-only peripheral behind a Wishbone classic slave port.
// Iterative core, one round per clock, round keys expanded on the fly.
// Ports: clk_i/rst_i clock and async active-high reset; adr_i/dat_i/sel_i/
// cyc_i/stb_i/we_i Wishbone request; dat_o/ack_o Wishbone response;
// irq level interrupt (RIS & IM).
//
// state      | meaning
// CORE_IDLE  | waiting for START, BUSY=0
// CORE_ROUND | one AES round per cycle, rounds_left counts down to 1
// CORE_LOAD  | copy final state into DOUT, raise DONE and RIS
module ef_aes_wb_slave
    import ef_aes_wb_slave_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    output logic        ack_o,
    output logic        irq
);

    localparam logic [3:0] NR_L = 4'(NR);

    logic [0:3][31:0] key_r, din_r, dout_r;
    logic             im_r, ris_r, done_r;
    core_state_t      core_st;
    logic [127:0]     state_r, rkey_r;
    logic [3:0]       rounds_left;

    logic [7:0]   addr;
    logic         bus_req, start_req, icr_clr, busy;
    logic [31:0]  rd_data;
    logic [127:0] sub_state, next_state, next_rkey, shifted, mixed;
    logic [31:0]  sub_w3, key_t;
    logic         unused_adr;

    assign addr       = adr_i[7:0];
    assign unused_adr = ^adr_i[31:8];
    assign bus_req    = cyc_i & stb_i & ~ack_o;
    assign busy       = (core_st != CORE_IDLE);
    assign start_req  = bus_req & we_i & (addr == CTRL_OFF) & sel_i[0] & dat_i[0];
    assign icr_clr    = bus_req & we_i & (addr == ICR_OFF) & sel_i[0] & dat_i[0];
    assign irq        = ris_r & im_r;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte r + 4c sits at bits [127-8(r+4c) -: 8]; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  sel);
        logic [31:0] o;
        o = old;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) o[8*i +: 8] = data[8*i +: 8];
        end
        return o;
    endfunction

    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox_state
        aes_sbox u_sbox (.value(state_r[8*gi +: 8]), .subst(sub_state[8*gi +: 8]));
    end

    // SubWord on the last key word; RotWord is applied afterwards since the
    // two operations commute.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox_key
        aes_sbox u_sbox (.value(rkey_r[8*gi +: 8]), .subst(sub_w3[8*gi +: 8]));
    end

    assign key_t = {sub_w3[23:0], sub_w3[31:24]} ^ {rcon(NR_L - rounds_left), 24'h0};
    assign next_rkey[127:96] = rkey_r[127:96] ^ key_t;
    assign next_rkey[95:64]  = rkey_r[95:64]  ^ next_rkey[127:96];
    assign next_rkey[63:32]  = rkey_r[63:32]  ^ next_rkey[95:64];
    assign next_rkey[31:0]   = rkey_r[31:0]   ^ next_rkey[63:32];

    assign shifted    = shift_rows(sub_state);
    assign mixed      = (rounds_left == 4'd1) ? shifted : mix_columns(shifted);
    assign next_state = mixed ^ next_rkey;

    always_comb begin
        rd_data = '0;
        case (addr)
            KEY0_OFF, KEY1_OFF, KEY2_OFF, KEY3_OFF:     rd_data = key_r[addr[3:2]];
            DIN0_OFF, DIN1_OFF, DIN2_OFF, DIN3_OFF:     rd_data = din_r[addr[3:2]];
            DOUT0_OFF, DOUT1_OFF, DOUT2_OFF, DOUT3_OFF: rd_data = dout_r[addr[3:2]];
            STATUS_OFF: begin
                rd_data[STATUS_BUSY_BIT] = busy;
                rd_data[STATUS_DONE_BIT] = done_r;
            end
            IM_OFF:  rd_data[0] = im_r;
            RIS_OFF: rd_data[0] = ris_r;
            MIS_OFF: rd_data[0] = ris_r & im_r;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_r       <= '0;
            din_r       <= '0;
            dout_r      <= '0;
            im_r        <= 1'b0;
            ris_r       <= 1'b0;
            done_r      <= 1'b0;
            core_st     <= CORE_IDLE;
            state_r     <= '0;
            rkey_r      <= '0;
            rounds_left <= '0;
            ack_o       <= 1'b0;
            dat_o       <= '0;
        end else begin
            ack_o <= bus_req;
            dat_o <= (bus_req && !we_i) ? rd_data : 32'h0;

            if (bus_req && we_i) begin
                case (addr)
                    KEY0_OFF, KEY1_OFF, KEY2_OFF, KEY3_OFF:
                        key_r[addr[3:2]] <= merge_lanes(key_r[addr[3:2]], dat_i, sel_i);
                    DIN0_OFF, DIN1_OFF, DIN2_OFF, DIN3_OFF:
                        din_r[addr[3:2]] <= merge_lanes(din_r[addr[3:2]], dat_i, sel_i);
                    IM_OFF: if (sel_i[0]) im_r <= dat_i[0];
                    default: ;
                endcase
            end

            if (icr_clr) ris_r <= 1'b0;

            // Placed after the ICR clear so a completion in the same cycle wins.
            case (core_st)
                CORE_IDLE: begin
                    if (start_req) begin
                        state_r     <= din_r ^ key_r;
                        rkey_r      <= key_r;
                        rounds_left <= NR_L;
                        done_r      <= 1'b0;
                        core_st     <= CORE_ROUND;
                    end
                end
                CORE_ROUND: begin
                    state_r     <= next_state;
                    rkey_r      <= next_rkey;
                    rounds_left <= rounds_left - 4'd1;
                    if (rounds_left == 4'd1) core_st <= CORE_LOAD;
                end
                CORE_LOAD: begin
                    dout_r  <= state_r;
                    done_r  <= 1'b1;
                    ris_r   <= 1'b1;
                    core_st <= CORE_IDLE;
                end
                default: core_st <= CORE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ef_aes_wb_slave.sv
// Directed self-checking bench for ef_aes_wb_slave using FIPS-197 vectors.
module tb_ef_aes_wb_slave;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel_i = '0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i  = 1'b0;
    logic        ack_o;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    int irq_rises = 0;
    logic irq_q = 1'b0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_IN   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_OUT  = 128'h3925841d02dc09fbdc118597196a0b32;

    ef_aes_wb_slave dut (
        .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .sel_i(sel_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .ack_o(ack_o), .irq(irq)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (irq && !irq_q) irq_rises++;
        irq_q = irq;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] sel);
        logic acked;
        acked = 1'b0;
        @(negedge clk_i);
        adr_i = {24'h0, addr}; dat_i = data; sel_i = sel; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
        for (int i = 0; i < 16 && !acked; i++) begin
            @(posedge clk_i); #1;
            acked = ack_o;
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        if (!acked) chk($sformatf("wr_ack_timeout_%02h", addr), 32'(acked), 32'h1);
    endtask

    task automatic wb_read(input logic [7:0] addr, output logic [31:0] data);
        logic acked;
        acked = 1'b0;
        data = 32'hxxxxxxxx;
        @(negedge clk_i);
        adr_i = {24'h0, addr}; sel_i = 4'h0; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
        for (int i = 0; i < 16 && !acked; i++) begin
            @(posedge clk_i); #1;
            acked = ack_o;
            if (acked) data = dat_o;
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        if (!acked) chk($sformatf("rd_ack_timeout_%02h", addr), 32'(acked), 32'h1);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(addr, d);
        chk(tag, d, exp);
    endtask

    task automatic write128(input logic [7:0] base, input logic [127:0] v);
        for (int i = 0; i < 4; i++) wb_write(base + 8'(4*i), v[127-32*i -: 32], 4'hf);
    endtask

    task automatic check_dout(input string tag, input logic [127:0] exp);
        for (int i = 0; i < 4; i++)
            rd_chk($sformatf("%s_dout%0d", tag, i), 8'h20 + 8'(4*i), exp[127-32*i -: 32]);
    endtask

    initial begin
        int rises0;

        // Reset with a bus request pending: no ack, no irq, dat_o quiet.
        cyc_i = 1'b1; stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("rst_ack", 32'(ack_o), 32'h0);
            chk("rst_irq", 32'(irq), 32'h0);
        end
        chk("rst_dat_o", dat_o, 32'h0);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int a = 0; a <= 'h44; a += 4) rd_chk($sformatf("rst_reg_%02h", a), 8'(a), 32'h0);
        rd_chk("unmapped_48", 8'h48, 32'h0);
        chk("rst_irq_after", 32'(irq), 32'h0);

        // Byte lanes and unmapped writes.
        wb_write(8'h00, 32'hAABBCCDD, 4'b0101);
        rd_chk("key0_lanes", 8'h00, 32'h00BB00DD);
        wb_write(8'h04, 32'h11223344, 4'b1000);
        rd_chk("key1_lanes", 8'h04, 32'h11000000);
        wb_write(8'h48, 32'hFFFFFFFF, 4'hf);
        rd_chk("unmapped_wr", 8'h48, 32'h0);
        wb_write(8'h38, 32'h1, 4'hf);
        rd_chk("im_rw", 8'h38, 32'h1);
        wb_write(8'h38, 32'h0, 4'hf);

        // FIPS-197 C.1 with IM=0; STATUS cycle boundary around completion.
        write128(8'h00, C1_KEY);
        write128(8'h10, C1_IN);
        rd_chk("din3_rb", 8'h1C, 32'hccddeeff);
        wb_write(8'h30, 32'h1, 4'hf);
        repeat (10) @(posedge clk_i);
        rd_chk("c1_status_busy", 8'h34, 32'h1);
        rd_chk("c1_status_done", 8'h34, 32'h2);
        check_dout("c1", C1_OUT);
        rd_chk("c1_ris", 8'h3C, 32'h1);
        rd_chk("c1_mis_masked", 8'h40, 32'h0);
        chk("c1_irq_masked", 32'(irq), 32'h0);
        rd_chk("ctrl_reads0", 8'h30, 32'h0);
        wb_write(8'h44, 32'h1, 4'hf);
        rd_chk("c1_ris_clr", 8'h3C, 32'h0);
        rd_chk("icr_reads0", 8'h44, 32'h0);

        // FIPS-197 Appendix B with IM=1; irq rises exactly 11 cycles after START.
        wb_write(8'h38, 32'h1, 4'hf);
        write128(8'h00, B_KEY);
        write128(8'h10, B_IN);
        wb_write(8'h30, 32'h1, 4'hf);
        repeat (10) @(posedge clk_i);
        #1 chk("b_irq_before", 32'(irq), 32'h0);
        @(posedge clk_i);
        #1 chk("b_irq_at_done", 32'(irq), 32'h1);
        rd_chk("b_mis", 8'h40, 32'h1);
        check_dout("b", B_OUT);
        wb_write(8'h44, 32'h1, 4'hf);
        #1 chk("b_irq_cleared", 32'(irq), 32'h0);
        rd_chk("b_ris_clr", 8'h3C, 32'h0);

        // Busy protection: DIN rewrite and second START while busy.
        write128(8'h00, C1_KEY);
        write128(8'h10, C1_IN);
        rises0 = irq_rises;
        wb_write(8'h30, 32'h1, 4'hf);
        wb_write(8'h10, 32'h0, 4'hf);
        wb_write(8'h14, 32'h0, 4'hf);
        wb_write(8'h30, 32'h1, 4'hf);
        repeat (30) @(posedge clk_i);
        chk("busy_done_events", 32'(irq_rises - rises0), 32'h1);
        rd_chk("busy_status", 8'h34, 32'h2);
        check_dout("busy", C1_OUT);
        rd_chk("busy_din0_updated", 8'h10, 32'h0);

        // Reset during round 5 aborts and clears everything.
        wb_write(8'h30, 32'h1, 4'hf);
        repeat (5) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 chk("abort_irq", 32'(irq), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        rd_chk("abort_status", 8'h34, 32'h0);
        check_dout("abort", 128'h0);
        rd_chk("abort_ris", 8'h3C, 32'h0);
        repeat (15) @(posedge clk_i);
        rd_chk("abort_no_done", 8'h34, 32'h0);
        check_dout("abort_late", 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ef_aes_wb_slave.md
Name: ef_aes_wb_slave

Overview:
- AES-128 encrypt-only peripheral with a Wishbone classic slave register interface and a level interrupt output.
- Software writes a 128-bit key and a 128-bit plaintext, sets START, and reads the 128-bit ciphertext once done.
- The core is iterative, one round per clock. It sits on the SoC peripheral bus as a memory-mapped slave.

Parameters:
- None. AES-128 only; 32-bit data bus; 8-bit address decode.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- adr_i  in  32  byte address; only [7:0] decoded, word aligned
- dat_i  in  32  write data
- dat_o  out  32  read data, valid while ack_o=1
- sel_i  in  4  byte-lane enables for writes
- cyc_i  in  1  bus cycle valid
- stb_i  in  1  strobe
- we_i  in  1  1=write, 0=read
- ack_o  out  1  transfer acknowledge
- irq  out  1  interrupt, level, active-high

Behaviour:
- Register map (word offsets):
  - 0x00-0x0C KEY0..KEY3, RW; KEY0 = key[127:96], KEY3 = key[31:0].
  - 0x10-0x1C DIN0..DIN3, RW; same word order.
  - 0x20-0x2C DOUT0..DOUT3, RO.
  - 0x30 CTRL, WO; bit0 START, self-clearing, reads as 0.
  - 0x34 STATUS, RO; bit0 BUSY, bit1 DONE.
  - 0x38 IM, RW; bit0 mask for DONE.
  - 0x3C RIS, RO.
  - 0x40 MIS, RO; equals RIS & IM.
  - 0x44 ICR, W1C onto RIS, reads 0.
  - Unmapped addresses read 0; writes to them are ignored.
- Bus handshake:
  - ack_o is registered and asserted for exactly one cycle, in the cycle after cyc_i&stb_i is first seen with ack_o=0. No back-to-back acks; wait states are fixed at 1.
  - The write takes effect on the edge that raises ack_o. Only lanes with sel_i=1 update.
  - dat_o is registered with ack_o. sel_i is ignored on reads.
- Core:
  - START accepted while BUSY=0: latch state = DIN ^ KEY and round key = KEY; round=1; BUSY=1; DONE=0.
  - Each following cycle performs one round: SubBytes, ShiftRows, MixColumns (omitted in round 10), AddRoundKey. The next round key is expanded on the fly (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36).
  - After round 10, DOUT loads the state, BUSY=0, DONE=1, and RIS[0] is set. DONE is therefore visible 11 cycles after the START-write edge.
  - START written while BUSY=1 is ignored.
  - KEY/DIN writes during BUSY update the registers but do not affect the in-flight operation.
  - DOUT holds its value until the next completion.
- State mapping: byte 0 = bits [127:120]; column-major per FIPS-197.
- Interrupt:
  - irq = |(RIS & IM), combinational from registers.
  - If an ICR clear and a RIS set happen in the same cycle, the set wins.
- Reset (async, rst_i=1): all registers 0, BUSY=0, DONE=0, ack_o=0, dat_o=0, irq=0. Reset mid-operation aborts it; DOUT is cleared.

Decomposition:
- Shared package holds:
  - register offset constants (KEY0_OFF.. ICR_OFF);
  - STATUS bit indices;
  - Rcon table;
  - the round-count constant NR=10.
- One sub-module, aes_sbox: combinational 8-bit forward S-box, instantiated 20 times (16 for state, 4 for key expansion).
- Round logic and MixColumns xtime live as functions in the main block.

Test Plan:
- Reset defaults: assert rst_i, then release. Read every register: all read 0, irq=0, ack_o=0 throughout reset.
- FIPS-197 C.1 vector:
  - Stimulus: KEY=000102030405060708090a0b0c0d0e0f, DIN=00112233445566778899aabbccddeeff, START.
  - Required: STATUS=0x1 within the round window, STATUS=0x2 after 11 cycles, DOUT0..3 = 69c4e0d8,6a7b0430,d8cdb780,70b4c55a.
- FIPS-197 Appendix B vector:
  - Stimulus: KEY=2b7e151628aed2a6abf7158809cf4f3c, DIN=3243f6a8885a308d313198a2e0370734.
  - Required: DOUT = 3925841d02dc09fbdc118597196a0b32.
- Interrupt: IM=1, run an encryption -> irq rises with DONE; MIS=1. Write ICR=1 -> irq=0, RIS=0. Repeat with IM=0 -> irq stays 0 and RIS=1.
- Busy protection: START, then mid-operation rewrite DIN to zeros and write START again. Required: the first result is unchanged (C.1 ciphertext) and only one DONE event occurs.
- Byte lanes and reset abort:
  - Write KEY0=0xAABBCCDD with sel_i=4'b0101 -> reads 0x00BB00DD.
  - Assert rst_i during round 5 -> BUSY=0, DOUT=0, irq=0.
